// File: rtl/fifo_word_packer_pkg.sv
// Shared constants and state encoding for the FIFO word packer.
package fifo_word_packer_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned DEF_WORD_BYTES = 2;
    localparam int unsigned DEF_BACKOFF    = 3;
    localparam int unsigned BO_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_BACKOFF = 2'd2
    } state_e;

    // Width able to hold 0..word_bytes (lane count plus one in-flight byte).
    function automatic int unsigned cnt_width(input int unsigned word_bytes);
        return $clog2(word_bytes + 1);
    endfunction

endpackage

// File: rtl/fifo_word_packer_byte_assembler.sv
// Lane register array: collects bytes little-endian and flags the completing byte.
module byte_assembler
    import fifo_word_packer_pkg::*;
#(
    parameter int unsigned  WORD_BYTES = DEF_WORD_BYTES,
    localparam int unsigned CNT_W      = cnt_width(WORD_BYTES)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr,
    input  logic                                cap_en,
    input  logic [BYTE_W-1:0]                   din,
    output logic [CNT_W-1:0]                    cnt,
    output logic                                partial,
    output logic [WORD_BYTES-1:0][BYTE_W-1:0]   word_c,
    output logic                                done_c
);

    logic [WORD_BYTES-1:0][BYTE_W-1:0] lane_q, lane_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              partial_q, partial_d;

    // Write the incoming byte into lane cnt; wrap cnt when the word is complete.
    always_comb begin
        lane_d = lane_q;
        cnt_d  = cnt_q;
        done_c = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cap_en) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    lane_d[i] = din;
                end
            end
            if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                done_c = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        partial_d = (cnt_d != '0);
    end

    // The completed word includes the byte arriving this cycle.
    assign word_c  = lane_d;
    assign cnt     = cnt_q;
    assign partial = partial_q;

    // Lane, count and partial-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q    <= '0;
            cnt_q     <= '0;
            partial_q <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Polls a byte FIFO, packs bytes little-endian into words, presents them valid/ready.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int unsigned  WORD_BYTES = DEF_WORD_BYTES,
    parameter int unsigned  BACKOFF    = DEF_BACKOFF,
    localparam int unsigned OUT_W      = BYTE_W * WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    output logic              fifo_ren,
    input  logic [BYTE_W-1:0] fifo_dout,
    input  logic              fifo_error,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              partial
);

    localparam int unsigned     CNT_W   = cnt_width(WORD_BYTES);
    localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF - 1);

    state_e                            state_q, state_d;
    logic                              pending_q, pending_d;
    logic [BO_W-1:0]                   bo_q, bo_d;
    logic                              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]                  out_data_q, out_data_d;

    logic [CNT_W-1:0]                  cnt;
    logic [CNT_W-1:0]                  slot_c;
    logic                              err_c;
    logic                              cap_en_c;
    logic                              room_c;
    logic                              ren_c;
    logic                              word_done_c;
    logic [WORD_BYTES-1:0][BYTE_W-1:0] word_c;

    // Lane storage and byte count.
    byte_assembler #(
        .WORD_BYTES (WORD_BYTES)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .cap_en  (cap_en_c),
        .din     (fifo_dout),
        .cnt     (cnt),
        .partial (partial),
        .word_c  (word_c),
        .done_c  (word_done_c)
    );

    // Slot counts the byte in flight so the final-byte read is only issued with a free output.
    always_comb begin
        slot_c   = cnt + CNT_W'(pending_q);
        err_c    = pending_q && fifo_error;
        cap_en_c = pending_q && !fifo_error && !flush;
        room_c   = (slot_c < CNT_W'(WORD_BYTES - 1)) ||
                   ((slot_c == CNT_W'(WORD_BYTES - 1)) && (!out_valid_q || out_ready));
    end

    // Next-state, read strobe and output register logic.
    always_comb begin
        state_d     = state_q;
        bo_d        = bo_q;
        ren_c       = 1'b0;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;

        if (word_done_c) begin
            out_valid_d = 1'b1;
            out_data_d  = word_c;
        end

        if (flush) begin
            state_d = enable ? ST_READ : ST_IDLE;
            bo_d    = '0;
        end else if (err_c) begin
            // The error cycle itself is the first idle cycle of the back-off.
            if (BACKOFF > 1) begin
                state_d = ST_BACKOFF;
                bo_d    = BO_LOAD;
            end else begin
                state_d = enable ? ST_READ : ST_IDLE;
                bo_d    = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        ren_c = room_c;
                    end
                end
                ST_BACKOFF: begin
                    if (bo_q <= BO_W'(1)) begin
                        state_d = enable ? ST_READ : ST_IDLE;
                        bo_d    = '0;
                    end else begin
                        bo_d = bo_q - BO_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (rst) begin
            ren_c = 1'b0;
        end
        pending_d = ren_c;
    end

    assign fifo_ren  = ren_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // State, in-flight flag, back-off counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            bo_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            bo_q        <= bo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO model plus a word-level reference model.
module tb_fifo_word_packer;

    localparam int WB = 2;
    localparam int BO = 3;
    localparam int OW = 8 * WB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_ren;
    logic [7:0]    fifo_dout = 8'h00;
    logic          fifo_error = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          partial;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO contents, partially assembled bytes, expected and received words.
    logic [7:0]    fq[$];
    logic [7:0]    acc[$];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];

    logic          resp_v = 1'b0;
    logic [7:0]    resp_b = 8'h00;

    logic          s_ren, s_valid, s_ready, s_partial, m_partial;
    logic [OW-1:0] s_data;

    logic          h_ren[$];
    logic          h_valid[$];
    logic          h_partial[$];
    logic [OW-1:0] h_data[$];

    fifo_word_packer #(
        .WORD_BYTES (WB),
        .BACKOFF    (BO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flush      (flush),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .fifo_error (fifo_error),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .partial    (partial)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One clock: sample at negedge, advance the models, answer reads after the edge.
    task automatic tick();
        logic [OW-1:0] w;
        @(negedge clk);
        s_ren     = fifo_ren;
        s_valid   = out_valid;
        s_ready   = out_ready;
        s_data    = out_data;
        s_partial = partial;
        m_partial = (acc.size() != 0);
        h_ren.push_back(s_ren);
        h_valid.push_back(s_valid);
        h_partial.push_back(s_partial);
        h_data.push_back(s_data);
        if (s_valid && s_ready && !rst) got_q.push_back(s_data);
        if (rst) begin
            acc.delete();
            exp_q.delete();
        end else if (flush) begin
            acc.delete();
        end else if (resp_v) begin
            acc.push_back(resp_b);
            if (acc.size() == WB) begin
                w = '0;
                for (int i = 0; i < WB; i++) w[8*i +: 8] = acc[i];
                exp_q.push_back(w);
                acc.delete();
            end
        end
        @(posedge clk);
        #1;
        resp_v = 1'b0;
        if (s_ren) begin
            if (fq.size() > 0) begin
                resp_b     = fq.pop_front();
                resp_v     = 1'b1;
                fifo_dout  = resp_b;
                fifo_error = 1'b0;
            end else begin
                fifo_dout  = 8'($urandom);
                fifo_error = 1'b1;
            end
        end else begin
            // Not a read response: error here is write-side noise and must be ignored.
            fifo_dout  = 8'($urandom);
            fifo_error = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; enable = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        fq.delete();
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic int first_ren(input int from);
        for (int i = from; i < h_ren.size(); i++) if (h_ren[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        tick();
        n_checks++; if (s_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
        n_checks++; if (s_data !== '0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", s_data); end
        n_checks++; if (s_partial !== 1'b0) begin n_errors++; $display("FAIL reset_partial: got %b expected 0", s_partial); end
        n_checks++; if (s_ren !== 1'b0) begin n_errors++; $display("FAIL reset_ren: got %b expected 0", s_ren); end
    endtask

    task automatic test_basic_word();
        int base, t;
        do_reset();
        fq.push_back(8'hA1); fq.push_back(8'hB2);
        out_ready = 1'b1; enable = 1'b1;
        base = h_ren.size();
        repeat (12) tick();
        t = first_ren(base);
        n_checks++;
        if (t < 0 || t + 4 >= h_ren.size()) begin
            n_errors++; $display("FAIL basic_first_ren: got index %0d expected a read within the window", t);
        end else begin
            n_checks++; if (h_ren[t+1] !== 1'b1) begin n_errors++; $display("FAIL basic_ren2: got %b expected 1", h_ren[t+1]); end
            n_checks++; if (h_ren[t+2] !== 1'b0) begin n_errors++; $display("FAIL basic_ren_bubble: got %b expected 0", h_ren[t+2]); end
            n_checks++; if (h_partial[t+2] !== 1'b1) begin n_errors++; $display("FAIL basic_partial: got %b expected 1", h_partial[t+2]); end
            n_checks++; if (h_valid[t+2] !== 1'b0) begin n_errors++; $display("FAIL basic_valid_early: got %b expected 0", h_valid[t+2]); end
            n_checks++; if (h_valid[t+3] !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b expected 1", h_valid[t+3]); end
            n_checks++; if (h_data[t+3] !== 16'hB2A1) begin n_errors++; $display("FAIL basic_data: got %h expected b2a1", h_data[t+3]); end
            n_checks++; if (h_partial[t+3] !== 1'b0) begin n_errors++; $display("FAIL basic_cnt_zero: got %b expected 0", h_partial[t+3]); end
            n_checks++; if (h_valid[t+4] !== 1'b0) begin n_errors++; $display("FAIL basic_valid_once: got %b expected 0", h_valid[t+4]); end
        end
        n_checks++; if (got_q.size() != 1) begin n_errors++; $display("FAIL basic_word_count: got %0d expected 1", got_q.size()); end
        enable = 1'b0;
    endtask

    task automatic test_empty_backoff();
        int base, t;
        do_reset();
        out_ready = 1'b1; enable = 1'b1;
        base = h_ren.size();
        repeat (20) tick();
        t = first_ren(base);
        n_checks++;
        if (t < 0 || t + 12 > h_ren.size()) begin
            n_errors++; $display("FAIL backoff_first_ren: got index %0d expected a read within the window", t);
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (h_ren[t+k] !== ((k % (BO + 1)) == 0)) begin
                    n_errors++; $display("FAIL backoff_pattern[%0d]: got %b expected %b", k, h_ren[t+k], (k % (BO + 1)) == 0);
                end
            end
        end
        for (int i = base; i < h_valid.size(); i++) begin
            n_checks++;
            if (h_valid[i] !== 1'b0 || h_partial[i] !== 1'b0) begin
                n_errors++; $display("FAIL backoff_no_word[%0d]: got valid %b partial %b expected 0 0", i - base, h_valid[i], h_partial[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        int base, rens;
        do_reset();
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44); fq.push_back(8'h55);
        out_ready = 1'b0; enable = 1'b1;
        repeat (14) tick();
        n_checks++; if (s_valid !== 1'b1) begin n_errors++; $display("FAIL bp_held_valid: got %b expected 1", s_valid); end
        n_checks++; if (s_data !== 16'h2211) begin n_errors++; $display("FAIL bp_held_data: got %h expected 2211", s_data); end
        n_checks++; if (s_partial !== 1'b1) begin n_errors++; $display("FAIL bp_stall_partial: got %b expected 1", s_partial); end
        rens = 0;
        for (int i = h_ren.size() - 6; i < h_ren.size(); i++) rens += int'(h_ren[i]);
        n_checks++; if (rens != 0) begin n_errors++; $display("FAIL bp_stall_reads: got %0d reads expected 0", rens); end
        out_ready = 1'b1;
        base = h_ren.size();
        repeat (16) tick();
        n_checks++;
        if (got_q.size() != 2) begin
            n_errors++; $display("FAIL bp_word_count: got %0d expected 2", got_q.size());
        end else begin
            n_checks++; if (got_q[0] !== 16'h2211) begin n_errors++; $display("FAIL bp_word0: got %h expected 2211", got_q[0]); end
            n_checks++; if (got_q[1] !== 16'h4433) begin n_errors++; $display("FAIL bp_word1: got %h expected 4433", got_q[1]); end
        end
        n_checks++; if (s_partial !== 1'b1 || s_valid !== 1'b0) begin n_errors++; $display("FAIL bp_tail_partial: got partial %b valid %b expected 1 0", s_partial, s_valid); end
        enable = 1'b0;
    endtask

    task automatic test_flush();
        int n;
        do_reset();
        fq.push_back(8'h7E); fq.push_back(8'h99);
        out_ready = 1'b1; enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_ren && n < 10);
        n_checks++;
        if (!s_ren) begin n_errors++; $display("FAIL flush_timeout: got no read expected one within 10 cycles"); return; end
        tick();
        n_checks++; if (s_ren !== 1'b1) begin n_errors++; $display("FAIL flush_second_read: got %b expected 1", s_ren); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (s_ren !== 1'b0) begin n_errors++; $display("FAIL flush_ren_blocked: got %b expected 0", s_ren); end
        n_checks++; if (s_partial !== 1'b1) begin n_errors++; $display("FAIL flush_pre_partial: got %b expected 1", s_partial); end
        fq.push_back(8'hC3); fq.push_back(8'hD4);
        tick();
        n_checks++; if (s_partial !== 1'b0) begin n_errors++; $display("FAIL flush_partial_clear: got %b expected 0", s_partial); end
        repeat (10) tick();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'hD4C3) begin
            n_errors++; $display("FAIL flush_fresh_word: got %0d words first %h expected 1 word d4c3", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_midop();
        int n;
        do_reset();
        fq.push_back(8'hA5); fq.push_back(8'h5A); fq.push_back(8'h77);
        out_ready = 1'b0; enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 12);
        n_checks++;
        if (!s_valid) begin n_errors++; $display("FAIL rstmid_timeout: got no word expected one within 12 cycles"); return; end
        n_checks++; if (s_data !== 16'h5AA5) begin n_errors++; $display("FAIL rstmid_word: got %h expected 5aa5", s_data); end
        n_checks++; if (s_ren !== 1'b1) begin n_errors++; $display("FAIL rstmid_inflight: got %b expected 1", s_ren); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (s_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got %b expected 0", s_valid); end
        n_checks++; if (s_data !== '0) begin n_errors++; $display("FAIL rstmid_data: got %h expected 0", s_data); end
        n_checks++; if (s_ren !== 1'b0) begin n_errors++; $display("FAIL rstmid_ren: got %b expected 0", s_ren); end
        n_checks++; if (s_partial !== 1'b0) begin n_errors++; $display("FAIL rstmid_partial: got %b expected 0", s_partial); end
        enable = 1'b0;
        repeat (4) tick();
        n_checks++; if (s_partial !== 1'b0 || got_q.size() != 0) begin n_errors++; $display("FAIL rstmid_dropped: got partial %b words %0d expected 0 0", s_partial, got_q.size()); end
    endtask

    task automatic test_enable_pause();
        int n, rens;
        do_reset();
        fq.push_back(8'h3C);
        out_ready = 1'b1; enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_ren && n < 10);
        n_checks++;
        if (!s_ren) begin n_errors++; $display("FAIL pause_timeout: got no read expected one within 10 cycles"); return; end
        enable = 1'b0;
        rens = 0;
        repeat (10) begin tick(); rens += int'(s_ren); end
        n_checks++; if (rens != 0) begin n_errors++; $display("FAIL pause_reads: got %0d reads expected 0", rens); end
        n_checks++; if (s_partial !== 1'b1) begin n_errors++; $display("FAIL pause_partial: got %b expected 1", s_partial); end
        fq.push_back(8'h9D);
        enable = 1'b1;
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 16'h9D3C) begin
            n_errors++; $display("FAIL pause_resume_word: got %0d words first %h expected 1 word 9d3c", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        logic          p_valid, p_ready;
        logic [OW-1:0] p_data, w, e;
        int            words;
        do_reset();
        p_valid = 1'b0; p_ready = 1'b0; p_data = '0; words = 0;
        enable = 1'b1;
        for (int c = 0; c < 3000 + 8; c++) begin
            if (c < 3000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 31) == 0) enable = ~enable;
                flush = ($urandom_range(0, 63) == 0);
                if (fq.size() < 8 && $urandom_range(0, 2) != 0) fq.push_back(8'($urandom));
            end else begin
                enable = 1'b0; flush = 1'b0; out_ready = 1'b1;
            end
            tick();
            n_checks++;
            if (s_partial !== m_partial) begin n_errors++; $display("FAIL rand_partial@%0d: got %b expected %b", c, s_partial, m_partial); end
            if (p_valid && !p_ready) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_data !== p_data) begin
                    n_errors++; $display("FAIL rand_hold@%0d: got valid %b data %h expected 1 %h", c, s_valid, s_data, p_data);
                end
            end
            p_valid = s_valid; p_ready = s_ready; p_data = s_data;
            while (got_q.size() > 0) begin
                w = got_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL rand_extra_word@%0d: got %h expected no word", c, w);
                end else begin
                    e = exp_q.pop_front();
                    words++;
                    if (w !== e) begin n_errors++; $display("FAIL rand_word@%0d: got %h expected %h", c, w, e); end
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_undelivered: got %0d words left expected 0", exp_q.size()); end
        n_checks++; if (words < 50) begin n_errors++; $display("FAIL rand_throughput: got %0d words expected at least 50", words); end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_empty_backoff();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_enable_pause();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
